// File: rtl/boot_loader_ctrl.sv
// Boot sequencer for the RISC-V core: loads firmware halfwords into program RAM while the
// CPU is held in reset, then releases the CPU and hands it the RAM port.
module boot_loader_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int RESET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_firm_wr,
  input  logic [15:0]       i_firm_data,
  output logic              o_firm_ack,
  input  logic              i_cpu_start,
  output logic              o_cpu_start_ack,
  output logic              o_cpu_reset,
  input  logic              i_cpu_mem_req,
  input  logic              i_cpu_mem_we,
  input  logic [ADDR_W-1:0] i_cpu_mem_addr,
  input  logic [31:0]       i_cpu_mem_wdata,
  input  logic [3:0]        i_cpu_mem_wmask,
  output logic [31:0]       o_cpu_mem_rdata,
  output logic              o_cpu_mem_ready,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  output logic [3:0]        o_ram_wmask,
  output logic              o_ram_we,
  input  logic [31:0]       i_ram_rdata,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_load_overflow,
  output logic [1:0]        o_dbg_state
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W:0]    r_ptr;
  logic [ADDR_W:0]    r_count;
  logic               r_overflow;
  logic               r_firm_ack;
  logic               r_start_ack;
  logic               r_mem_ready;
  logic [CNT_W-1:0]   r_rel_cnt;

  logic               w_fw_accept;
  logic               w_start_load;
  logic               w_start_run;
  logic               w_start_accept;
  logic               w_run_to_load;

  // Handshakes: the bridge holds firm_wr / cpu_start until it sees the matching one-cycle
  // ack; a request is taken only while its ack is low, so the ack cycle never re-accepts.
  always_comb begin
    w_fw_accept    = (r_state == S_LOAD) && i_firm_wr && !r_firm_ack && !reset;
    w_start_load   = (r_state == S_LOAD) && i_cpu_start && !i_firm_wr && !r_firm_ack
                     && !r_start_ack;
    w_run_to_load  = (r_state == S_RUN) && i_firm_wr;
    w_start_run    = (r_state == S_RUN) && i_cpu_start && !i_firm_wr && !r_start_ack;
    w_start_accept = w_start_load || w_start_run;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_start_load) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (r_rel_cnt == '0) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_run_to_load)    w_state_nxt = S_LOAD;
        else if (w_start_run) w_state_nxt = S_RELEASE;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // RAM port mux: loader owns it in LOAD, CPU owns it in RUN, idle otherwise.
  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_wmask = '0;
    if (w_fw_accept) begin
      o_ram_we    = 1'b1;
      o_ram_addr  = r_ptr[ADDR_W:1];
      o_ram_wdata = {i_firm_data, i_firm_data};
      o_ram_wmask = r_ptr[0] ? 4'b1100 : 4'b0011;
    end else if ((r_state == S_RUN) && !reset) begin
      o_ram_we    = i_cpu_mem_req && i_cpu_mem_we;
      o_ram_addr  = i_cpu_mem_addr;
      o_ram_wdata = i_cpu_mem_wdata;
      o_ram_wmask = i_cpu_mem_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_ptr       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_firm_ack  <= 1'b0;
      r_start_ack <= 1'b0;
      r_mem_ready <= 1'b0;
      r_rel_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_firm_ack  <= w_fw_accept;
      r_start_ack <= w_start_accept;
      // An access issued in the cycle the CPU loses the port never completes.
      r_mem_ready <= (r_state == S_RUN) && i_cpu_mem_req && (w_state_nxt == S_RUN);
      if (w_run_to_load) begin
        r_ptr      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_fw_accept) begin
        r_ptr   <= r_ptr + (ADDR_W+1)'(1);
        r_count <= r_count + (ADDR_W+1)'(1);
        if (&r_ptr) r_overflow <= 1'b1;
      end
      if (w_start_accept) begin
        r_rel_cnt <= CNT_W'(RESET_CYCLES - 1);
      end else if ((r_state == S_RELEASE) && (r_rel_cnt != '0)) begin
        r_rel_cnt <= r_rel_cnt - CNT_W'(1);
      end
    end
  end

  assign o_firm_ack      = r_firm_ack;
  assign o_cpu_start_ack = r_start_ack;
  assign o_cpu_reset     = (r_state != S_RUN);
  assign o_cpu_mem_ready = r_mem_ready;
  assign o_cpu_mem_rdata = i_ram_rdata;
  assign o_load_count    = r_count;
  assign o_load_overflow = r_overflow;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: a 4K-word instance for the main flows and a 4-word
// instance (same stimulus) for halfword-pointer wrap.
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        firm_wr = 1'b0;
  logic [15:0] firm_data = '0;
  logic        cpu_start = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wmask = '0;

  logic        a_firm_ack, a_start_ack, a_cpu_reset, a_ready, a_ram_we, a_ovf;
  logic [31:0] a_rdata, a_ram_wdata, a_ram_rdata;
  logic [11:0] a_ram_addr;
  logic [3:0]  a_ram_wmask;
  logic [12:0] a_count;
  logic [1:0]  a_state;

  logic        b_firm_ack, b_start_ack, b_cpu_reset, b_ready, b_ram_we, b_ovf;
  logic [31:0] b_rdata, b_ram_wdata, b_ram_rdata;
  logic [1:0]  b_ram_addr;
  logic [3:0]  b_ram_wmask;
  logic [2:0]  b_count;
  logic [1:0]  b_state;

  logic [31:0] ram_a [0:4095];
  logic [31:0] ram_b [0:3];
  logic [31:0] exp_a [0:4095];
  logic [31:0] exp_b [0:3];

  int checks = 0;
  int errors = 0;
  bit track = 1'b0;
  int we_cnt = 0;
  int ack_cnt = 0;
  int start_cnt = 0;

  int m_ptr_a, m_ptr_b, m_count_a, m_count_b;
  bit m_ovf_a, m_ovf_b, m_cpu_reset, m_run;

  always #5 clk = ~clk;

  boot_loader_ctrl #(.ADDR_W(12), .RESET_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset),
    .i_firm_wr(firm_wr), .i_firm_data(firm_data), .o_firm_ack(a_firm_ack),
    .i_cpu_start(cpu_start), .o_cpu_start_ack(a_start_ack), .o_cpu_reset(a_cpu_reset),
    .i_cpu_mem_req(cpu_req), .i_cpu_mem_we(cpu_we), .i_cpu_mem_addr(cpu_addr),
    .i_cpu_mem_wdata(cpu_wdata), .i_cpu_mem_wmask(cpu_wmask),
    .o_cpu_mem_rdata(a_rdata), .o_cpu_mem_ready(a_ready),
    .o_ram_addr(a_ram_addr), .o_ram_wdata(a_ram_wdata), .o_ram_wmask(a_ram_wmask),
    .o_ram_we(a_ram_we), .i_ram_rdata(a_ram_rdata),
    .o_load_count(a_count), .o_load_overflow(a_ovf), .o_dbg_state(a_state)
  );

  boot_loader_ctrl #(.ADDR_W(2), .RESET_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset),
    .i_firm_wr(firm_wr), .i_firm_data(firm_data), .o_firm_ack(b_firm_ack),
    .i_cpu_start(cpu_start), .o_cpu_start_ack(b_start_ack), .o_cpu_reset(b_cpu_reset),
    .i_cpu_mem_req(cpu_req), .i_cpu_mem_we(cpu_we), .i_cpu_mem_addr(cpu_addr[1:0]),
    .i_cpu_mem_wdata(cpu_wdata), .i_cpu_mem_wmask(cpu_wmask),
    .o_cpu_mem_rdata(b_rdata), .o_cpu_mem_ready(b_ready),
    .o_ram_addr(b_ram_addr), .o_ram_wdata(b_ram_wdata), .o_ram_wmask(b_ram_wmask),
    .o_ram_we(b_ram_we), .i_ram_rdata(b_ram_rdata),
    .o_load_count(b_count), .o_load_overflow(b_ovf), .o_dbg_state(b_state)
  );

  // Synchronous RAMs with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (a_ram_we)
      for (int i = 0; i < 4; i++)
        if (a_ram_wmask[i]) ram_a[a_ram_addr][8*i +: 8] <= a_ram_wdata[8*i +: 8];
    a_ram_rdata <= ram_a[a_ram_addr];
  end

  always @(posedge clk) begin
    if (b_ram_we)
      for (int i = 0; i < 4; i++)
        if (b_ram_wmask[i]) ram_b[b_ram_addr][8*i +: 8] <= b_ram_wdata[8*i +: 8];
    b_ram_rdata <= ram_b[b_ram_addr];
  end

  always @(posedge clk) if (a_ram_we === 1'b1) we_cnt++;

  always @(negedge clk) begin
    if (track && a_firm_ack === 1'b1) ack_cnt++;
    if (track && a_start_ack === 1'b1) start_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle after the first reset the observable load state must
  // follow the model.
  always @(negedge clk) begin
    if (track) begin
      check("cmp_cpu_reset_a", 32'(a_cpu_reset), 32'(m_cpu_reset));
      check("cmp_cpu_reset_b", 32'(b_cpu_reset), 32'(m_cpu_reset));
      check("cmp_count_a", 32'(a_count), m_count_a);
      check("cmp_count_b", 32'(b_count), m_count_b);
      check("cmp_ovf_a", 32'(a_ovf), 32'(m_ovf_a));
      check("cmp_ovf_b", 32'(b_ovf), 32'(m_ovf_b));
      check("cmp_acks_b_vs_a", 32'({b_firm_ack, b_start_ack}), 32'({a_firm_ack, a_start_ack}));
      if (m_cpu_reset) check("cmp_no_ready_in_reset", 32'(a_ready), 0);
    end
  end

  task automatic model_enter_load();
    m_ptr_a = 0; m_ptr_b = 0; m_count_a = 0; m_count_b = 0;
    m_ovf_a = 1'b0; m_ovf_b = 1'b0; m_cpu_reset = 1'b1; m_run = 1'b0;
  endtask

  task automatic model_hw(input logic [15:0] d);
    if (m_ptr_a % 2 == 1) exp_a[m_ptr_a / 2][31:16] = d;
    else                  exp_a[m_ptr_a / 2][15:0]  = d;
    m_ptr_a = m_ptr_a + 1;
    if (m_ptr_a == 8192) begin m_ptr_a = 0; m_ovf_a = 1'b1; end
    m_count_a = (m_count_a + 1) % 8192;
    if (m_ptr_b % 2 == 1) exp_b[m_ptr_b / 2][31:16] = d;
    else                  exp_b[m_ptr_b / 2][15:0]  = d;
    m_ptr_b = m_ptr_b + 1;
    if (m_ptr_b == 8) begin m_ptr_b = 0; m_ovf_b = 1'b1; end
    m_count_b = (m_count_b + 1) % 8;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_reset"}, 32'(a_cpu_reset), 1);
    check({tag, "_firm_ack"}, 32'(a_firm_ack), 0);
    check({tag, "_start_ack"}, 32'(a_start_ack), 0);
    check({tag, "_ready"}, 32'(a_ready), 0);
    check({tag, "_ram_we"}, 32'(a_ram_we), 0);
    check({tag, "_ram_addr"}, 32'(a_ram_addr), 0);
    check({tag, "_ram_wdata"}, a_ram_wdata, 0);
    check({tag, "_ram_wmask"}, 32'(a_ram_wmask), 0);
    check({tag, "_count_a"}, 32'(a_count), 0);
    check({tag, "_ovf_a"}, 32'(a_ovf), 0);
    check({tag, "_count_b"}, 32'(b_count), 0);
    check({tag, "_ovf_b"}, 32'(b_ovf), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_enter_load();
  endtask

  // Offer one halfword; from RUN the first edge only switches to LOAD.
  task automatic send_half(input logic [15:0] d, input bit hold);
    bit got = 1'b0;
    firm_wr = 1'b1;
    firm_data = d;
    if (m_run) begin
      @(posedge clk); #1;
      model_enter_load();
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (a_firm_ack) begin got = 1'b1; break; end
    end
    check("firm_ack_seen", 32'(got), 1);
    model_hw(d);
    if (!hold) firm_wr = 1'b0;
    @(posedge clk); #1;
    check("firm_ack_one_cycle", 32'(a_firm_ack), 0);
    firm_wr = 1'b0;
  endtask

  task automatic start_cpu(input bit full);
    bit got = 1'b0;
    cpu_start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (a_start_ack) begin got = 1'b1; break; end
    end
    check("start_ack_seen", 32'(got), 1);
    cpu_start = 1'b0;
    m_cpu_reset = 1'b1;
    m_run = 1'b0;
    if (full) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        check("release_cpu_reset_high", 32'(a_cpu_reset), 1);
        if (k == 0) check("start_ack_one_cycle", 32'(a_start_ack), 0);
      end
      @(posedge clk); #1;
      m_cpu_reset = 1'b0;
      m_run = 1'b1;
      check("release_cpu_reset_falls", 32'(a_cpu_reset), 0);
    end
  endtask

  task automatic cpu_read(input int addr);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'(addr);
    @(posedge clk); #1;
    check("rd_ready", 32'(a_ready), 1);
    check("rd_data_model", a_rdata, exp_a[addr]);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("rd_ready_drop", 32'(a_ready), 0);
  endtask

  task automatic cpu_write(input int addr, input logic [31:0] data, input logic [3:0] mask);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'(addr);
    cpu_wdata = data; cpu_wmask = mask;
    @(posedge clk); #1;
    check("wr_ready", 32'(a_ready), 1);
    for (int i = 0; i < 4; i++)
      if (mask[i]) exp_a[addr][8*i +: 8] = data[8*i +: 8];
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wmask = '0;
    @(posedge clk); #1;
    check("wr_ready_drop", 32'(a_ready), 0);
  endtask

  initial begin
    int we0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_enter_load();
    track = 1'b1;
    check_reset_outputs("reset");

    // Load four halfwords
    we0 = we_cnt;
    send_half(16'h1111, 1'b0);
    send_half(16'h2222, 1'b0);
    send_half(16'h3333, 1'b0);
    send_half(16'h4444, 1'b0);
    check("load4_ram0", ram_a[0], 32'h22221111);
    check("load4_ram1", ram_a[1], 32'h44443333);
    check("load4_count", 32'(a_count), 4);
    check("load4_acks", ack_cnt, 4);
    check("load4_writes", we_cnt - we0, 4);

    // Start and run
    start_cpu(1'b1);
    check("start_acks", start_cnt, 1);
    cpu_read(1);
    check("rd1_literal", a_rdata, 32'h44443333);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd0;
    @(posedge clk); #1;
    check("b2b_ready0", 32'(a_ready), 1);
    check("b2b_data0", a_rdata, 32'h22221111);
    cpu_addr = 12'd1;
    @(posedge clk); #1;
    check("b2b_ready1", 32'(a_ready), 1);
    check("b2b_data1", a_rdata, 32'h44443333);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("b2b_ready_drop", 32'(a_ready), 0);

    // CPU byte write, then firmware write from RUN
    cpu_write(5, 32'hDEADBEEF, 4'b0100);
    check("cpuwr_byte2", 32'(ram_a[5][23:16]), 32'h0000_00AD);
    cpu_read(5);
    send_half(16'hABCD, 1'b0);
    check("reload_cpu_reset", 32'(a_cpu_reset), 1);
    check("reload_ram0", ram_a[0], 32'h2222ABCD);
    check("reload_count", 32'(a_count), 1);

    // Held firm_wr through the ack cycle and a firm_wr/cpu_start tie
    we0 = we_cnt;
    send_half(16'h1234, 1'b1);
    check("hold_one_write", we_cnt - we0, 1);
    check("hold_ram0", ram_a[0], 32'h1234ABCD);
    cpu_start = 1'b1;
    send_half(16'h5678, 1'b0);
    check("tie_start_not_yet", 32'(a_start_ack), 0);
    start_cpu(1'b1);
    check("tie_ram1", ram_a[1], 32'h44445678);
    cpu_read(1);

    // Pointer wrap on the small instance
    pulse_reset();
    check_reset_outputs("reset_run");
    for (int i = 0; i < 9; i++) send_half(16'h0100 + 16'(i), 1'b0);
    check("wrap_ovf_b", 32'(b_ovf), 1);
    check("wrap_count_b", 32'(b_count), 1);
    check("wrap_ramb0", ram_b[0], 32'h01010108);
    check("wrap_ramb1", ram_b[1], 32'h01030102);
    check("wrap_count_a", 32'(a_count), 9);
    check("wrap_ovf_a", 32'(a_ovf), 0);
    check("wrap_rama4_low", 32'(ram_a[4][15:0]), 32'h0000_0108);
    start_cpu(1'b1);
    check("ovf_sticky_in_run", 32'(b_ovf), 1);
    send_half(16'h00EE, 1'b0);
    check("ovf_cleared_on_load", 32'(b_ovf), 0);
    check("reload_ramb0_low", 32'(ram_b[0][15:0]), 32'h0000_00EE);

    // Reset during RELEASE
    start_cpu(1'b0);
    @(posedge clk); #1;
    pulse_reset();
    check_reset_outputs("reset_rel");
    send_half(16'h5555, 1'b0);
    check("after_rel_reset_ram0", ram_a[0], 32'h01015555);

    // Reset mid-load with a halfword pending
    send_half(16'h6666, 1'b0);
    send_half(16'h7777, 1'b0);
    we0 = we_cnt;
    firm_wr = 1'b1;
    firm_data = 16'h8888;
    pulse_reset();
    firm_wr = 1'b0;
    check("midload_no_write", we_cnt - we0, 0);
    check_reset_outputs("reset_load");
    send_half(16'h9999, 1'b0);
    check("midload_ram0", ram_a[0], 32'h66669999);
    check("midload_ram1", ram_a[1], 32'h01037777);

    for (int w = 0; w < 4; w++) check("final_ram_vs_model", ram_a[w], exp_a[w]);

    @(posedge clk); #1;
    track = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
